imem_loader: RTL



---
 rtl/imem_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed, checksummed byte stream,
// writes little-endian words into the instruction memory and releases the core on success.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        load_start,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] len;
  logic [31:0] word_idx;
  logic [31:0] shift_reg;
  logic [7:0]  csum;
  logic        accept;
  logic        last_byte;
  logic [31:0] len_word;
  logic [31:0] data_word;

  assign accept    = rx_valid & rx_ready;
  assign last_byte = (byte_cnt == 2'd3);
  // Bytes arrive LSB first, so each new byte enters at the top and the word shifts down.
  assign len_word  = {rx_data, len[31:8]};
  assign data_word = {rx_data, shift_reg[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LEN;
    end else begin
      state <= state_nxt;
    end
  end

  // rx_ready and the status outputs decode only the state register.
  always_comb begin
    state_nxt  = state;
    rx_ready   = 1'b0;
    core_reset = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      S_LEN: begin
        rx_ready = 1'b1;
        if (accept && last_byte) begin
          if (len_word > DEPTH_WORDS) begin
            state_nxt = S_ERR;
          end else if (len_word == '0) begin
            state_nxt = S_CSUM;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (accept && last_byte && (word_idx == len - 32'd1)) begin
          state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (accept) begin
          state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
        if (load_start) begin
          state_nxt = S_LEN;
        end
      end
      S_ERR: begin
        load_error = 1'b1;
        if (load_start) begin
          state_nxt = S_LEN;
        end
      end
      default: state_nxt = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      len        <= '0;
      word_idx   <= '0;
      shift_reg  <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN: begin
          if (accept) begin
            len      <= len_word;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            shift_reg <= data_word;
            csum      <= csum ^ rx_data;
            byte_cnt  <= byte_cnt + 2'd1;
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_wdata <= data_word;
              imem_addr  <= BASE_ADDR + {word_idx[29:0], 2'b00};
              word_idx   <= word_idx + 32'd1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (load_start) begin
            byte_cnt  <= '0;
            len       <= '0;
            word_idx  <= '0;
            shift_reg <= '0;
            csum      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
